pc_reg: RTL and testbench

- Program-counter register for the CPU datapath: a WIDTH-bit edge-triggered storage element with synchronous active-low reset and a load enable.
- Sits between next-PC selection logic (drives in) and instruction fetch (consumes out).
- Pure register: no increment or arithmetic inside the block.

---
 rtl/pc_reg_pkg.sv | 9 +
 rtl/pc_reg.sv | 52 +++++
 tb/tb_pc_reg.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pc_reg_pkg.sv
// Shared program-counter definitions for datapath blocks that pass PC values.
package pc_reg_pkg;

  localparam int unsigned PC_WIDTH       = 32;
  localparam logic [31:0] PC_RESET_VALUE = 32'h0000_0000;

  typedef logic [PC_WIDTH-1:0] pc_t;

endpackage : pc_reg_pkg

// File: rtl/pc_reg.sv
// Program-counter register: WIDTH-bit load-enabled register with synchronous active-low reset.
// Optional PC_REG_ALIGN_CHECK_EN adds a registered, advisory word-misalignment flag.
module pc_reg
  import pc_reg_pkg::*;
#(
  parameter int unsigned WIDTH       = PC_WIDTH,
  parameter logic [31:0] RESET_VALUE = PC_RESET_VALUE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic [WIDTH-1:0] in,
`ifdef PC_REG_ALIGN_CHECK_EN
  output logic             misaligned,
`endif
  output logic [WIDTH-1:0] out
);

  // RESET_VALUE is always 32 bits; fit it to the datapath width.
  localparam logic [WIDTH-1:0] LP_RESET = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc <= LP_RESET;
    end else if (ena) begin
      r_pc <= in;
    end
  end

  assign out = r_pc;

`ifdef PC_REG_ALIGN_CHECK_EN
  logic r_misaligned;
  logic w_low_bits_set;

  // Flag tracks the value being loaded; out itself is never altered.
  assign w_low_bits_set = (in[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_misaligned <= 1'b0;
    end else if (ena) begin
      r_misaligned <= w_low_bits_set;
    end
  end

  assign misaligned = r_misaligned;
`endif

endmodule : pc_reg

// File: tb/tb_pc_reg.sv
// Directed testbench for pc_reg; define PC_REG_ALIGN_CHECK_EN to also check the alignment flag.
module tb_pc_reg;
  import pc_reg_pkg::*;

  logic clk;
  logic reset;
  logic ena;
  pc_t  pc_in;
  pc_t  pc_out;
`ifdef PC_REG_ALIGN_CHECK_EN
  logic misaligned;
`endif

  int total = 0;
  int bad   = 0;

  pc_reg #(
    .WIDTH      (PC_WIDTH),
    .RESET_VALUE(PC_RESET_VALUE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ena       (ena),
    .in        (pc_in),
`ifdef PC_REG_ALIGN_CHECK_EN
    .misaligned(misaligned),
`endif
    .out       (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle to the falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b0;
    ena   = 1'b0;
    pc_in = '0;

    // Reset held for two edges
    step();
    step();
    check("reset_value", pc_out, 32'h0);
`ifdef PC_REG_ALIGN_CHECK_EN
    check("reset_flag", {31'b0, misaligned}, 32'h0);
`endif

    // Reset overrides a load request
    pc_in = 32'd10;
    ena   = 1'b1;
    step();
    check("reset_over_load", pc_out, 32'h0);

    // Load
    reset = 1'b1;
    pc_in = 32'd100;
    step();
    check("load_100", pc_out, 32'd100);
    pc_in = 32'd50;
    step();
    check("load_50", pc_out, 32'd50);

    // Hold across three edges
    ena   = 1'b0;
    pc_in = 32'd100;
    step();
    check("hold_1", pc_out, 32'd50);
    step();
    check("hold_2", pc_out, 32'd50);
    step();
    check("hold_3", pc_out, 32'd50);

    // Priority: reset beats a simultaneous load
    ena   = 1'b1;
    pc_in = 32'd150;
    step();
    check("load_150", pc_out, 32'd150);
    reset = 1'b0;
    step();
    check("prio_reset", pc_out, 32'h0);
    reset = 1'b1;
    pc_in = 32'd100;
    step();
    check("release_load", pc_out, 32'd100);

    // Reset glitch entirely between edges must be ignored
    ena = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    @(negedge clk);
    check("glitch_mid", pc_out, 32'd100);
    step();
    check("glitch_edge", pc_out, 32'd100);

    // ena pulse between edges has no effect
    pc_in = 32'd7;
    ena   = 1'b1;
    #2 ena = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ena_glitch", pc_out, 32'd100);

    // Unknown input while disabled must not leak into out
    pc_in = 'x;
    step();
    check("x_in_hold", pc_out, 32'd100);

    // All-ones boundary value
    ena   = 1'b1;
    pc_in = 32'hFFFF_FFFF;
    step();
    check("load_ones", pc_out, 32'hFFFF_FFFF);

`ifdef PC_REG_ALIGN_CHECK_EN
    pc_in = 32'h102;
    step();
    check("align_out_102", pc_out, 32'h102);
    check("align_flag_102", {31'b0, misaligned}, 32'h1);
    pc_in = 32'h104;
    step();
    check("align_flag_104", {31'b0, misaligned}, 32'h0);
    pc_in = 32'h103;
    step();
    check("align_flag_103", {31'b0, misaligned}, 32'h1);
    ena   = 1'b0;
    pc_in = 32'h200;
    step();
    check("align_flag_hold", {31'b0, misaligned}, 32'h1);
    reset = 1'b0;
    step();
    check("align_flag_reset", {31'b0, misaligned}, 32'h0);
    reset = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pc_reg
